mesh_edge_port_bank: RTL and testbench

//  Bank of per-terminal ingress FIFOs feeding every edge port of the mesh_gnrtr array.

---
 rtl/mesh_edge_port_bank.sv | 127 ++++++++++++
 tb/tb_mesh_edge_port_bank.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_edge_port_bank.sv
// mesh_edge_port_bank: per-edge-terminal ingress FIFOs feeding the mesh_gnrtr router ports.
// Optional macro PORT_STATS_EN adds saturating accepted/dropped packet counters per channel.
module mesh_edge_port_bank #(
  parameter int ROWS       = 4,
  parameter int COLUMS     = 4,
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  localparam int CHANNELS  = 2*ROWS + 2*COLUMS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS-1:0]         push,
  input  logic [CHANNELS*pckg_sz-1:0] data_in,
  output logic [CHANNELS-1:0]         full,
  output logic [CHANNELS-1:0]         overflow,
  output logic [CHANNELS-1:0]         reject,
  output logic [CHANNELS*pckg_sz-1:0] data_out_i_in,
  output logic [CHANNELS-1:0]         pndng_i_in,
  input  logic [CHANNELS-1:0]         popin,
  output logic [CHANNELS*16-1:0]      acc_cnt,
  output logic [CHANNELS*16-1:0]      drop_cnt
);
  localparam int AW = $clog2(fifo_depth);

  // Edge terminals are numbered top row, left column, bottom row, right column.
  function automatic logic [3:0] self_row(input int c);
    if (c < COLUMS)               return 4'd0;
    else if (c < COLUMS + ROWS)   return 4'(c - COLUMS + 1);
    else if (c < 2*COLUMS + ROWS) return 4'(ROWS + 1);
    else                          return 4'(c - 2*COLUMS - ROWS + 1);
  endfunction

  function automatic logic [3:0] self_col(input int c);
    if (c < COLUMS)               return 4'(c + 1);
    else if (c < COLUMS + ROWS)   return 4'd0;
    else if (c < 2*COLUMS + ROWS) return 4'(c - COLUMS - ROWS + 1);
    else                          return 4'(COLUMS + 1);
  endfunction

`ifdef PORT_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam logic [3:0] SELF_ROW = self_row(c);
    localparam logic [3:0] SELF_COL = self_col(c);

    logic [pckg_sz-1:0] mem [fifo_depth];
    logic [pckg_sz-1:0] din, dout_q, head_nxt;
    logic [AW-1:0]      rd_ptr, wr_ptr, rd_nxt;
    logic [AW:0]        count, count_nxt;
    logic               full_q, pndng_q, ovf_q, rej_q;
    logic               self_hit, pop_eff, acc, ovf_hit, rej_hit;

    assign din      = data_in[c*pckg_sz +: pckg_sz];
    assign self_hit = (din[pckg_sz-9 -: 4] == SELF_ROW) && (din[pckg_sz-13 -: 4] == SELF_COL);
    assign pop_eff  = popin[c] && pndng_q;
    assign acc      = push[c] && (!full_q || popin[c]) && !self_hit;
    assign rej_hit  = push[c] && self_hit;
    assign ovf_hit  = push[c] && !self_hit && full_q && !popin[c];

    assign rd_nxt    = rd_ptr + AW'(pop_eff);
    assign count_nxt = count + (AW+1)'(acc) - (AW+1)'(pop_eff);

    // The new head is the pushed word only when the queue drains to it this cycle.
    always_comb begin
      head_nxt = dout_q;
      if (count_nxt != '0)
        head_nxt = (acc && wr_ptr == rd_nxt) ? din : mem[rd_nxt];
    end

    always_ff @(posedge clk) begin
      if (acc) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count   <= '0;
        full_q  <= 1'b0;
        pndng_q <= 1'b0;
        ovf_q   <= 1'b0;
        rej_q   <= 1'b0;
        dout_q  <= '0;
      end else begin
        rd_ptr  <= rd_nxt;
        wr_ptr  <= wr_ptr + AW'(acc);
        count   <= count_nxt;
        full_q  <= (count_nxt == (AW+1)'(fifo_depth));
        pndng_q <= (count_nxt != '0);
        ovf_q   <= ovf_q | ovf_hit;
        rej_q   <= rej_q | rej_hit;
        dout_q  <= head_nxt;
      end
    end

    assign full[c]                               = full_q;
    assign pndng_i_in[c]                         = pndng_q;
    assign overflow[c]                           = ovf_q;
    assign reject[c]                             = rej_q;
    assign data_out_i_in[c*pckg_sz +: pckg_sz]   = dout_q;

`ifdef PORT_STATS_EN
    logic [15:0] acc_q, drop_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        acc_q  <= '0;
        drop_q <= '0;
      end else begin
        acc_q  <= sat_inc(acc_q, acc);
        drop_q <= sat_inc(drop_q, ovf_hit || rej_hit);
      end
    end

    assign acc_cnt[c*16 +: 16]  = acc_q;
    assign drop_cnt[c*16 +: 16] = drop_q;
`else
    assign acc_cnt[c*16 +: 16]  = '0;
    assign drop_cnt[c*16 +: 16] = '0;
`endif
  end

endmodule

// File: tb/tb_mesh_edge_port_bank.sv
// Self-checking bench for mesh_edge_port_bank: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_mesh_edge_port_bank;
  localparam int ROWS = 4, COLS = 4, PW = 40, D = 4;
  localparam int CH = 2*ROWS + 2*COLS;

  logic              clk, reset;
  logic [CH-1:0]     push, popin, full, overflow, reject, pndng_i_in;
  logic [CH*PW-1:0]  data_in, data_out_i_in;
  logic [CH*16-1:0]  acc_cnt, drop_cnt;

  int n_chk = 0, n_pass = 0;

  logic [PW-1:0] mq [CH][$];
  logic [PW-1:0] m_head [CH];
  bit            m_ovf [CH], m_rej [CH];
  int            m_acc [CH], m_drop [CH];

  mesh_edge_port_bank #(.ROWS(ROWS), .COLUMS(COLS), .pckg_sz(PW), .fifo_depth(D)) dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .full(full),
    .overflow(overflow), .reject(reject), .data_out_i_in(data_out_i_in),
    .pndng_i_in(pndng_i_in), .popin(popin), .acc_cnt(acc_cnt), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] srow(input int c);
    if (c < COLS) return 4'd0;
    if (c < COLS + ROWS) return 4'(c - COLS + 1);
    if (c < 2*COLS + ROWS) return 4'(ROWS + 1);
    return 4'(c - 2*COLS - ROWS + 1);
  endfunction

  function automatic logic [3:0] scol(input int c);
    if (c < COLS) return 4'(c + 1);
    if (c < COLS + ROWS) return 4'd0;
    if (c < 2*COLS + ROWS) return 4'(c - COLS - ROWS + 1);
    return 4'(COLS + 1);
  endfunction

  function automatic logic [PW-1:0] mkpkt(input logic [3:0] r, input logic [3:0] cl,
                                          input logic [22:0] pay);
    return {8'hA5, r, cl, 1'b0, pay};
  endfunction

  function automatic logic [CH*PW-1:0] on_ch(input int c, input logic [PW-1:0] p);
    logic [CH*PW-1:0] v;
    v = '0;
    v[c*PW +: PW] = p;
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      mq[c].delete();
      m_head[c] = '0; m_ovf[c] = 0; m_rej[c] = 0; m_acc[c] = 0; m_drop[c] = 0;
    end
  endtask

  task automatic model_edge(input logic [CH-1:0] pv, input logic [CH-1:0] ppv,
                            input logic [CH*PW-1:0] dv);
    for (int c = 0; c < CH; c++) begin
      logic [PW-1:0] d;
      bit slf, was_full;
      d = dv[c*PW +: PW];
      slf = (d[PW-9 -: 4] == srow(c)) && (d[PW-13 -: 4] == scol(c));
      was_full = (mq[c].size() == D);
      if (ppv[c] && mq[c].size() != 0) void'(mq[c].pop_front());
      if (pv[c]) begin
        if (slf) begin
          m_rej[c] = 1; if (m_drop[c] < 65535) m_drop[c]++;
        end else if (was_full && !ppv[c]) begin
          m_ovf[c] = 1; if (m_drop[c] < 65535) m_drop[c]++;
        end else begin
          mq[c].push_back(d); if (m_acc[c] < 65535) m_acc[c]++;
        end
      end
      if (mq[c].size() != 0) m_head[c] = mq[c][0];
    end
  endtask

  task automatic step(input logic [CH-1:0] pv, input logic [CH-1:0] ppv,
                      input logic [CH*PW-1:0] dv);
    push = pv; popin = ppv; data_in = dv;
    @(posedge clk);
    model_edge(pv, ppv, dv);
    #1;
    push = '0; popin = '0;
  endtask

  task automatic apply_reset();
    push = '0; popin = '0; data_in = '0;
    @(negedge clk); reset = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++; if (full !== '0) $display("FAIL rst_full got %h want 0", full); else n_pass++;
    n_chk++; if (overflow !== '0) $display("FAIL rst_ovf got %h want 0", overflow); else n_pass++;
    n_chk++; if (reject !== '0) $display("FAIL rst_rej got %h want 0", reject); else n_pass++;
    n_chk++; if (pndng_i_in !== '0) $display("FAIL rst_pndng got %h want 0", pndng_i_in); else n_pass++;
    n_chk++; if (data_out_i_in !== '0) $display("FAIL rst_dout got %h want 0", data_out_i_in); else n_pass++;
    n_chk++; if (acc_cnt !== '0) $display("FAIL rst_acc got %h want 0", acc_cnt); else n_pass++;
    n_chk++; if (drop_cnt !== '0) $display("FAIL rst_drop got %h want 0", drop_cnt); else n_pass++;
  endtask

  task automatic test_basic();
    logic [PW-1:0] p;
    p = mkpkt(4'd2, 4'd3, 23'h1234);
    step(16'h0001, '0, on_ch(0, p));
    n_chk++; if (pndng_i_in[0] !== 1'b1) $display("FAIL basic_pndng got %b want 1", pndng_i_in[0]); else n_pass++;
    n_chk++; if (data_out_i_in[0 +: PW] !== p) $display("FAIL basic_dout got %h want %h", data_out_i_in[0 +: PW], p); else n_pass++;
    step('0, 16'h0001, '0);
    n_chk++; if (pndng_i_in[0] !== 1'b0) $display("FAIL basic_pop got %b want 0", pndng_i_in[0]); else n_pass++;
    n_chk++; if (data_out_i_in[0 +: PW] !== p) $display("FAIL basic_hold got %h want %h", data_out_i_in[0 +: PW], p); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [PW-1:0] p [5];
    for (int i = 0; i < 5; i++) p[i] = mkpkt(4'd1, 4'd1, 23'(i + 1));
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (full[5] !== 1'b0) $display("FAIL ovf_notfull_%0d got %b want 0", i, full[5]); else n_pass++;
      step(16'h0020, '0, on_ch(5, p[i]));
    end
    n_chk++; if (full[5] !== 1'b1) $display("FAIL ovf_full got %b want 1", full[5]); else n_pass++;
    n_chk++; if (overflow[5] !== 1'b0) $display("FAIL ovf_early got %b want 0", overflow[5]); else n_pass++;
    step(16'h0020, '0, on_ch(5, p[4]));
    n_chk++; if (overflow[5] !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow[5]); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (data_out_i_in[5*PW +: PW] !== p[i]) $display("FAIL ovf_order_%0d got %h want %h", i, data_out_i_in[5*PW +: PW], p[i]); else n_pass++;
      step('0, 16'h0020, '0);
    end
    n_chk++; if (pndng_i_in[5] !== 1'b0) $display("FAIL ovf_empty got %b want 0", pndng_i_in[5]); else n_pass++;
    n_chk++; if (overflow[5] !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow[5]); else n_pass++;
  endtask

  task automatic test_full_push_pop();
    logic [PW-1:0] p [4];
    logic [PW-1:0] x;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      p[i] = mkpkt(4'd3, 4'd3, 23'(16 + i));
      step(16'h0020, '0, on_ch(5, p[i]));
    end
    x = mkpkt(4'd3, 4'd3, 23'h7ABCD);
    step(16'h0020, 16'h0020, on_ch(5, x));
    n_chk++; if (full[5] !== 1'b1) $display("FAIL fpp_full got %b want 1", full[5]); else n_pass++;
    n_chk++; if (overflow[5] !== 1'b0) $display("FAIL fpp_ovf got %b want 0", overflow[5]); else n_pass++;
    n_chk++; if (data_out_i_in[5*PW +: PW] !== p[1]) $display("FAIL fpp_head got %h want %h", data_out_i_in[5*PW +: PW], p[1]); else n_pass++;
    for (int i = 0; i < 3; i++) step('0, 16'h0020, '0);
    n_chk++; if (data_out_i_in[5*PW +: PW] !== x) $display("FAIL fpp_new got %h want %h", data_out_i_in[5*PW +: PW], x); else n_pass++;
    step('0, 16'h0020, '0);
    n_chk++; if (pndng_i_in[5] !== 1'b0) $display("FAIL fpp_drain got %b want 0", pndng_i_in[5]); else n_pass++;
    // Pop on empty channel plus a push: push wins, pop ignored.
    step(16'h0020, 16'h0020, on_ch(5, p[0]));
    n_chk++; if (pndng_i_in[5] !== 1'b1) $display("FAIL fpp_emptypop got %b want 1", pndng_i_in[5]); else n_pass++;
  endtask

  task automatic test_reject();
    step(16'h0010, '0, on_ch(4, mkpkt(4'd1, 4'd0, 23'h55)));
    n_chk++; if (reject[4] !== 1'b1) $display("FAIL rej_set got %b want 1", reject[4]); else n_pass++;
    n_chk++; if (pndng_i_in[4] !== 1'b0) $display("FAIL rej_pndng got %b want 0", pndng_i_in[4]); else n_pass++;
    step(16'h0010, '0, on_ch(4, mkpkt(4'd1, 4'd1, 23'h66)));
    n_chk++; if (pndng_i_in[4] !== 1'b1) $display("FAIL rej_accept got %b want 1", pndng_i_in[4]); else n_pass++;
    n_chk++; if (data_out_i_in[4*PW +: PW] !== mkpkt(4'd1, 4'd1, 23'h66)) $display("FAIL rej_data got %h", data_out_i_in[4*PW +: PW]); else n_pass++;
    n_chk++; if (reject[4] !== 1'b1) $display("FAIL rej_sticky got %b want 1", reject[4]); else n_pass++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 4; i++)
      step(i < 3 ? 16'h000C : 16'h0008, '0,
           on_ch(2, mkpkt(4'd2, 4'd2, 23'(i))) | on_ch(3, mkpkt(4'd2, 4'd2, 23'(i))));
    n_chk++; if (pndng_i_in[2] !== 1'b1 || full[3] !== 1'b1) $display("FAIL arst_pre got %b/%b want 1/1", pndng_i_in[2], full[3]); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_chk++; if (pndng_i_in !== '0) $display("FAIL arst_pndng got %h want 0", pndng_i_in); else n_pass++;
    n_chk++; if (full !== '0) $display("FAIL arst_full got %h want 0", full); else n_pass++;
    model_reset();
    @(negedge clk) reset = 1'b1;
    step(16'h0004, '0, on_ch(2, mkpkt(4'd2, 4'd2, 23'h99)));
    n_chk++; if (pndng_i_in[2] !== 1'b1) $display("FAIL arst_after got %b want 1", pndng_i_in[2]); else n_pass++;
    n_chk++; if (data_out_i_in[2*PW +: PW] !== mkpkt(4'd2, 4'd2, 23'h99)) $display("FAIL arst_data got %h", data_out_i_in[2*PW +: PW]); else n_pass++;
  endtask

  task automatic test_stats();
    logic [PW-1:0] p;
    int exp_acc, exp_drop;
    apply_reset();
    p = mkpkt(4'd1, 4'd1, 23'h3);
    for (int i = 0; i < 4; i++) step(16'h0080, '0, on_ch(7, p));
    for (int i = 0; i < 2; i++) step(16'h0080, '0, on_ch(7, p));
    for (int i = 0; i < 6; i++) step(16'h0080, 16'h0080, on_ch(7, p));
    step(16'h0080, '0, on_ch(7, mkpkt(4'd4, 4'd0, 23'h1)));
`ifdef PORT_STATS_EN
    exp_acc = 10; exp_drop = 3;
`else
    exp_acc = 0; exp_drop = 0;
`endif
    n_chk++; if (acc_cnt[7*16 +: 16] !== 16'(exp_acc)) $display("FAIL stats_acc got %0d want %0d", acc_cnt[7*16 +: 16], exp_acc); else n_pass++;
    n_chk++; if (drop_cnt[7*16 +: 16] !== 16'(exp_drop)) $display("FAIL stats_drop got %0d want %0d", drop_cnt[7*16 +: 16], exp_drop); else n_pass++;
    n_chk++; if (overflow[7] !== 1'b1 || reject[7] !== 1'b1) $display("FAIL stats_flags got %b%b want 11", overflow[7], reject[7]); else n_pass++;
  endtask

  task automatic test_random();
    logic [CH-1:0]    pv, ppv;
    logic [CH*PW-1:0] dv;
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      pv  = CH'($urandom) & CH'($urandom | $urandom);
      ppv = CH'($urandom);
      for (int c = 0; c < CH; c++) begin
        logic [PW-1:0] d;
        d = {$urandom, 8'($urandom)};
        if ($urandom_range(0, 7) == 0) begin
          d[PW-9 -: 4]  = srow(c);
          d[PW-13 -: 4] = scol(c);
        end
        dv[c*PW +: PW] = d;
      end
      step(pv, ppv, dv);
      for (int c = 0; c < CH; c++) begin
        int ea, ed;
`ifdef PORT_STATS_EN
        ea = m_acc[c]; ed = m_drop[c];
`else
        ea = 0; ed = 0;
`endif
        n_chk++; if (pndng_i_in[c] !== (mq[c].size() != 0)) $display("FAIL rnd_pndng c%0d cyc%0d got %b want %0d", c, cyc, pndng_i_in[c], mq[c].size()); else n_pass++;
        n_chk++; if (full[c] !== (mq[c].size() == D)) $display("FAIL rnd_full c%0d cyc%0d got %b want size %0d", c, cyc, full[c], mq[c].size()); else n_pass++;
        n_chk++; if (overflow[c] !== m_ovf[c] || reject[c] !== m_rej[c]) $display("FAIL rnd_flags c%0d cyc%0d got %b%b want %b%b", c, cyc, overflow[c], reject[c], m_ovf[c], m_rej[c]); else n_pass++;
        n_chk++; if (data_out_i_in[c*PW +: PW] !== m_head[c]) $display("FAIL rnd_dout c%0d cyc%0d got %h want %h", c, cyc, data_out_i_in[c*PW +: PW], m_head[c]); else n_pass++;
        n_chk++; if (acc_cnt[c*16 +: 16] !== 16'(ea) || drop_cnt[c*16 +: 16] !== 16'(ed)) $display("FAIL rnd_cnt c%0d cyc%0d got %0d/%0d want %0d/%0d", c, cyc, acc_cnt[c*16 +: 16], drop_cnt[c*16 +: 16], ea, ed); else n_pass++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; push = '0; popin = '0; data_in = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_reject();
    test_async_reset();
    test_stats();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
